// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT datapath blocks.
//   - Default and maximum frame-size constants (N = 1 << LOG2_N).
//   - bank_t: index of one of the two ping-pong storage banks.
//   - frame_len(): frame length in words for a given log2 size.
//   - bitrev():    reverses the low 'width' bits of an index. Bits above
//                  'width' are returned as zero.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int LOG2_N_DEFAULT     = 3;
    localparam int LOG2_N_MAX         = 8;
    localparam int DATA_WIDTH_DEFAULT = 8;

    // Two banks, so a single bit selects one.
    typedef logic bank_t;

    function automatic int frame_len(input int log2n);
        return 1 << log2n;
    endfunction

    function automatic logic [LOG2_N_MAX-1:0] bitrev(
        input logic [LOG2_N_MAX-1:0] idx,
        input int                    width
    );
        logic [LOG2_N_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2_N_MAX; i++) begin
            if (i < width) r[i] = idx[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_index.sv
// -----------------------------------------------------------------------------
// bitrev_index
// Combinational index reverser: rev[i] = idx[WIDTH-1-i].
// Ports:
//   idx  in  WIDTH  natural-order index
//   rev  out WIDTH  bit-reversed index
// -----------------------------------------------------------------------------
module bitrev_index #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] idx,
    output logic [WIDTH-1:0] rev
);

    always_comb begin
        rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev[i] = idx[WIDTH-1-i];
        end
    end

endmodule

// File: rtl/bitrev_reorder_buffer.sv
// -----------------------------------------------------------------------------
// bitrev_reorder_buffer
// Streaming natural-order to bit-reversed-order reorder buffer. Two register
// banks of 2^LOG2_N words are used ping-pong: one fills while the other drains,
// giving 1 word/cycle sustained on both sides.
//
// Optional feature (macro BITREV_ORDER_SEL_EN): adds input bitrev_en, sampled on
// the first accepted word of each frame. A frame captured with bitrev_en=0 is
// read back in natural order; with bitrev_en=1 it is read bit-reversed.
// Without the macro every frame is read bit-reversed.
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous reset, active-high
//   in_data    in   DATA_WIDTH  sample, natural order
//   in_valid   in   1           in_data valid
//   in_ready   out  1           buffer accepts a sample this cycle
//   out_data   out  DATA_WIDTH  sample, bit-reversed order
//   out_valid  out  1           out_data valid
//   out_ready  in   1           downstream accepts out_data
//   out_last   out  1           final word of a frame (qualified by out_valid)
//   bitrev_en  in   1           (BITREV_ORDER_SEL_EN only) per-frame order select
// -----------------------------------------------------------------------------
module bitrev_reorder_buffer
    import fft_pkg::*;
#(
    parameter int LOG2_N     = LOG2_N_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef BITREV_ORDER_SEL_EN
    input  logic                  bitrev_en,
`endif
    output logic                  out_last
);

    localparam int                N        = frame_len(LOG2_N);
    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

    // NOTE: the sample storage carries no reset; its contents are never
    // observable until a bank has been completely rewritten and flagged full,
    // so clearing it would only cost reset fan-out.
    logic [DATA_WIDTH-1:0] mem [2][N];

    logic [1:0]        full;
    logic [1:0]        full_next;
    bank_t             wr_bank;
    bank_t             rd_bank;
    logic [LOG2_N-1:0] wr_cnt;
    logic [LOG2_N-1:0] rd_cnt;
    logic [LOG2_N-1:0] rev_cnt;
    logic [LOG2_N-1:0] rd_addr;

    logic wr_fire;
    logic rd_fire;
    logic wr_done;
    logic rd_done;

    // Handshakes. A bank being filled is never full, and a bank being drained
    // is always full, so each side only looks at its own bank's flag.
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_last  = out_valid && (rd_cnt == LAST_IDX);

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_done = wr_fire && (wr_cnt == LAST_IDX);
    assign rd_done = rd_fire && out_last;

    bitrev_index #(
        .WIDTH (LOG2_N)
    ) u_bitrev_index (
        .idx (rd_cnt),
        .rev (rev_cnt)
    );

`ifdef BITREV_ORDER_SEL_EN
    // Per-bank read order: 1 = bit-reversed, 0 = natural passthrough.
    logic [1:0] order;

    always_ff @(posedge clk) begin
        if (rst) begin
            order <= 2'b11;
        end else if (wr_fire && (wr_cnt == '0)) begin
            order[wr_bank] <= bitrev_en;
        end
    end

    assign rd_addr = order[rd_bank] ? rev_cnt : rd_cnt;
`else
    assign rd_addr = rev_cnt;
`endif

    // Combinational read of registered storage; holds while out_ready is low
    // because rd_bank and rd_cnt only move on an accepted read.
    assign out_data = mem[rd_bank][rd_addr];

    // Set and clear can land in the same cycle but always on different banks:
    // the set targets the (not full) write bank, the clear the (full) read bank.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        full_next = full;
        if (wr_done) full_next[wr_bank] = 1'b1;
        if (rd_done) full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            full    <= 2'b00;
        end else begin
            // Counters are exactly LOG2_N bits wide, so they wrap to 0 after
            // the last word of a frame without an explicit compare.
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_done) rd_bank <= ~rd_bank;
            end
            full <= full_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_cnt] <= in_data;
        end
    end

endmodule

// File: tb/tb_bitrev_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_bitrev_reorder_buffer
// Self-checking bench for bitrev_reorder_buffer (LOG2_N=3, DATA_WIDTH=8).
// A frame-level reference model collects accepted words into frames and, once
// a frame is complete, queues its words in bit-reversed order. Every cycle the
// bench checks in_ready/out_valid against the number of stored frames, and
// out_data/out_last against the head of the expected queue.
// -----------------------------------------------------------------------------
module tb_bitrev_reorder_buffer;

    localparam int L  = 3;
    localparam int N  = 1 << L;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
`ifdef BITREV_ORDER_SEL_EN
    logic          bitrev_en;
`endif

    bitrev_reorder_buffer #(
        .LOG2_N     (L),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BITREV_ORDER_SEL_EN
        .bitrev_en (bitrev_en),
`endif
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          en;
    } src_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    src_t          src_q[$];   // words waiting to be offered
    exp_t          exp_q[$];   // words the DUT must still emit, in order
    logic [DW-1:0] frame_q[$]; // accepted words of the frame being written
    logic          frame_ord;  // read order of the frame being written
    logic [DW-1:0] log_q[$];   // words accepted from the DUT
    int            pending;    // complete frames not yet fully read
    int            in_ready_low;

    int checks;
    int errors;

    // Bit-reversal of a frame index, by arithmetic on its binary digits.
    function automatic int rev_idx(input int i);
        int r;
        int v;
        r = 0;
        v = i;
        for (int b = 0; b < L; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic model_clear();
        src_q.delete();
        exp_q.delete();
        frame_q.delete();
        log_q.delete();
        pending      = 0;
        in_ready_low = 0;
        frame_ord    = 1'b1;
    endtask

    task automatic push_frame(input int start, input logic en);
        for (int i = 0; i < N; i++) begin
            src_q.push_back('{data: DW'(start + i), en: en});
        end
    endtask

    // One clock cycle: drive at posedge+1, check and update model at negedge.
    task automatic step(input int pin, input int pout);
        logic wr_acc;
        logic rd_acc;
        exp_t e;
        if (src_q.size() > 0 && $urandom_range(99) < pin) begin
            in_valid = 1'b1;
            in_data  = src_q[0].data;
`ifdef BITREV_ORDER_SEL_EN
            bitrev_en = src_q[0].en;
`endif
        end else begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
        end
        out_ready = ($urandom_range(99) < pout);

        @(negedge clk);
        checks++;
        if (in_ready !== (pending < 2)) begin
            errors++;
            $display("FAIL in_ready: got %b, expected %b (frames stored %0d)",
                     in_ready, (pending < 2), pending);
        end
        checks++;
        if (out_valid !== (pending > 0)) begin
            errors++;
            $display("FAIL out_valid: got %b, expected %b (frames stored %0d)",
                     out_valid, (pending > 0), pending);
        end
        if (pending > 0) begin
            checks++;
            if (out_data !== exp_q[0].data) begin
                errors++;
                $display("FAIL out_data: got %0d, expected %0d", out_data, exp_q[0].data);
            end
            checks++;
            if (out_last !== exp_q[0].last) begin
                errors++;
                $display("FAIL out_last: got %b, expected %b", out_last, exp_q[0].last);
            end
        end
        if (src_q.size() > 0 && in_ready !== 1'b1) in_ready_low++;

        wr_acc = in_valid && (pending < 2);
        rd_acc = out_ready && (pending > 0);

        if (rd_acc) begin
            e = exp_q.pop_front();
            log_q.push_back(e.data);
            if (e.last) pending--;
        end
        if (wr_acc) begin
`ifdef BITREV_ORDER_SEL_EN
            if (frame_q.size() == 0) frame_ord = src_q[0].en;
`else
            frame_ord = 1'b1;
`endif
            frame_q.push_back(src_q[0].data);
            void'(src_q.pop_front());
            if (frame_q.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    exp_q.push_back('{data: frame_q[frame_ord ? rev_idx(k) : k],
                                      last: (k == N - 1)});
                end
                frame_q.delete();
                pending++;
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int pin, input int pout, input int budget);
        int n;
        n = 0;
        while ((src_q.size() > 0 || pending > 0) && n < budget) begin
            step(pin, pout);
            n++;
        end
        checks++;
        if (src_q.size() > 0 || pending > 0) begin
            errors++;
            $display("FAIL timeout: %0d words unsent, %0d frames undrained after %0d cycles",
                     src_q.size(), pending, budget);
        end
    endtask

    task automatic check_log(input string name, input int expv[]);
        checks++;
        if (log_q.size() != expv.size()) begin
            errors++;
            $display("FAIL %s length: got %0d words, expected %0d", name, log_q.size(), expv.size());
        end else begin
            for (int i = 0; i < expv.size(); i++) begin
                checks++;
                if (log_q[i] !== DW'(expv[i])) begin
                    errors++;
                    $display("FAIL %s word %0d: got %0d, expected %0d", name, i, log_q[i], expv[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef BITREV_ORDER_SEL_EN
        bitrev_en = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if (out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset out_last: got %b, expected 0", out_last);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %b, expected 1", in_ready);
        end
        model_clear();
    endtask

    task automatic test_single_frame();
        model_clear();
        push_frame(0, 1'b1);
        // 8 write cycles, first output one cycle later, 8 read cycles.
        repeat (16) step(100, 100);
        check_log("single_frame", '{0, 4, 2, 6, 1, 5, 3, 7});
    endtask

    task automatic test_back_to_back();
        model_clear();
        push_frame(0, 1'b1);
        push_frame(8, 1'b1);
        push_frame(16, 1'b1);
        repeat (32) step(100, 100);
        check_log("back_to_back", '{0, 4, 2, 6, 1, 5, 3, 7,
                                    8, 12, 10, 14, 9, 13, 11, 15,
                                    16, 20, 18, 22, 17, 21, 19, 23});
        checks++;
        if (in_ready_low != 0) begin
            errors++;
            $display("FAIL back_to_back in_ready drops: got %0d cycles, expected 0", in_ready_low);
        end
    endtask

    task automatic test_stall();
        model_clear();
        push_frame(100, 1'b1);
        push_frame(108, 1'b1);
        src_q.push_back('{data: DW'(116), en: 1'b1});
        repeat (30) step(100, 0);
        checks++;
        if (src_q.size() != 1) begin
            errors++;
            $display("FAIL stall accepted: got %0d words, expected 16", 17 - src_q.size());
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall in_ready: got %b, expected 0", in_ready);
        end
        for (int i = 117; i < 124; i++) src_q.push_back('{data: DW'(i), en: 1'b1});
        run_until_idle(100, 100, 200);
        check_log("stall", '{100, 104, 102, 106, 101, 105, 103, 107,
                             108, 112, 110, 114, 109, 113, 111, 115,
                             116, 120, 118, 122, 117, 121, 119, 123});
    endtask

    task automatic test_random();
        model_clear();
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) begin
                src_q.push_back('{data: DW'($urandom), en: 1'b1});
            end
        end
        run_until_idle(50, 50, 3000);
        checks++;
        if (log_q.size() != 20 * N) begin
            errors++;
            $display("FAIL random word count: got %0d, expected %0d", log_q.size(), 20 * N);
        end
    endtask

    task automatic test_reset_mid_frame();
        model_clear();
        for (int i = 0; i < 5; i++) src_q.push_back('{data: DW'(i), en: 1'b1});
        repeat (5) step(100, 100);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset flags: got out_valid=%b in_ready=%b, expected 0 and 1",
                     out_valid, in_ready);
        end
        push_frame(8, 1'b1);
        run_until_idle(100, 100, 100);
        check_log("mid_reset", '{8, 12, 10, 14, 9, 13, 11, 15});
    endtask

`ifdef BITREV_ORDER_SEL_EN
    task automatic test_order_sel();
        model_clear();
        push_frame(0, 1'b0);
        push_frame(8, 1'b1);
        run_until_idle(100, 100, 100);
        check_log("order_sel", '{0, 1, 2, 3, 4, 5, 6, 7,
                                 8, 12, 10, 14, 9, 13, 11, 15});
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid_frame();
`ifdef BITREV_ORDER_SEL_EN
        test_order_sel();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitrev_reorder_buffer.md
Name: bitrev_reorder_buffer

Overview:
- Streaming reorder buffer that converts a natural-order sample stream into bit-reversed order, one frame of 2^LOG2_N words at a time.
- It generalises the combinational index reverser into a sequential block with ping-pong storage and valid/ready handshakes on both sides.
- It sits between the sample source and the radix-2 FFT core, or after a DIF FFT core to restore natural order.

Parameters:
- LOG2_N, 3, log2 of frame length; legal range 2..8.
- DATA_WIDTH, 8, width of one sample word.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  DATA_WIDTH  sample, natural order.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  buffer accepts a sample this cycle.
- out_data  out  DATA_WIDTH  sample, bit-reversed order.
- out_valid  out  1  out_data is valid this cycle.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  marks the final word of a frame; qualified by out_valid.

Behaviour:
- Storage is 2 banks × 2^LOG2_N words × DATA_WIDTH, register-based.
- State:
  - wr_bank, rd_bank: 1 bit each.
  - wr_cnt, rd_cnt: LOG2_N bits each.
  - full[1:0]: one flag per bank.
- Reset values: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full=2'b00.
  - Output values during reset: in_ready=1 the cycle after reset deasserts; out_valid=0, out_last=0.
  - out_data has no reset value; it is don't-care while out_valid=0.
- Write side:
  - in_ready = !full[wr_bank].
  - On in_valid && in_ready: mem[wr_bank][wr_cnt] <= in_data and wr_cnt increments.
  - When wr_cnt == 2^LOG2_N-1 on an accepted write: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = mem[rd_bank][reverse(rd_cnt)]; this is a combinational read of registered storage.
  - out_last = out_valid && (rd_cnt == 2^LOG2_N-1).
  - On out_valid && out_ready: rd_cnt increments.
  - On an accepted out_last: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
- Per-bank states: EMPTY → FILLING → FULL → DRAINING → EMPTY. FILLING is implied by wr_bank selection; DRAINING is implied by rd_bank selection.
- Latency: the first output word (index 0) is valid one cycle after the final write of the frame is accepted. Sustained throughput is 1 word/cycle each side.
- Boundary conditions:
  - Both banks full: in_ready=0. The writer stalls; nothing is dropped and wr_cnt holds.
  - Both banks empty: out_valid=0 and rd_cnt holds.
  - Same cycle, write completes bank A while read completes bank B: both full-flag updates apply. Set and clear never target the same bank in one cycle.
  - out_ready low while out_valid=1: out_data and out_last hold stable.
  - in_valid low mid-frame: the partial frame is retained, with no timeout.
  - rst mid-frame: all partial and full frames are discarded. Counters and flags return to reset values on the next edge.

Optional Feature:
- Macro: BITREV_ORDER_SEL_EN.
- With the macro defined:
  - Extra input port bitrev_en (1 bit) and one-bit register order[1:0] per bank.
  - bitrev_en is sampled on the first accepted write of each frame (wr_cnt==0) into order[wr_bank].
  - When order[rd_bank]=0, the read address is rd_cnt (natural-order passthrough); when 1, it is reverse(rd_cnt).
  - The order register resets to 1.
- Without the macro: no port, and the output is always bit-reversed.

Decomposition:
- Shared package fft_pkg holds:
  - localparam-style constants for frame length N = 1<<LOG2_N.
  - The bank-index type.
  - Helper function bitrev(idx, width).
- One sub-module is natural: bitrev_index, a parametrised combinational index reverser (width LOG2_N) driving the read address.

Test Plan:
- LOG2_N=3, in_data 0..7 streamed back-to-back, out_ready=1 → out_data 0,4,2,6,1,5,3,7; out_last on the 8th word; first out_valid 1 cycle after the 8th write.
- Three frames back-to-back (values 0..23), out_ready=1 → continuous 1 word/cycle output and in_ready never drops.
- out_ready held 0 while 16 words are offered → in_ready falls after 16 accepted; word 17 is stalled until the first output is accepted; no loss or duplication.
- Random in_valid/out_ready toggling (50%) over 20 frames → output matches the scoreboard bit-reversal of each frame.
- rst asserted after 5 of 8 writes, then a fresh frame 8..15 → output 8,12,10,14,9,13,11,15; no stale data appears.
- With BITREV_ORDER_SEL_EN: frame A with bitrev_en=0, frame B with bitrev_en=1 → A emerges natural 0..7, B emerges bit-reversed.
